// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one active-low column at a time, rows sampled
// through a 2-flop synchronizer, press/release debounced over full scan frames.
module keypad_scanner #(
    parameter int unsigned basys_clk       = 100_000_000,
    parameter int unsigned scan_hz         = 1000,
    parameter int unsigned debounce_frames = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam logic [31:0] STEP_DIV = 32'(basys_clk / scan_hz - 1);
    localparam logic [3:0]  DF       = 4'(debounce_frames);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    logic [3:0]  row_s1_q, row_s2_q;
    logic [31:0] step_q, step_d;
    logic [1:0]  cidx_q, cidx_d;
    logic [1:0]  acc_n_q, acc_n_d;
    logic [3:0]  acc_code_q, acc_code_d;
    state_t      state_q, state_d;
    logic [3:0]  cand_q, cand_d;
    logic [3:0]  dcnt_q, dcnt_d;
    logic [3:0]  code_q, code_d;
    logic        valid_q, valid_d;
    logic        held_q, held_d;

    logic        tick, frame_done;
    logic [3:0]  samp;
    logic [2:0]  nhits, sum;
    logic [1:0]  rsel;
    logic [1:0]  frame_n;
    logic [3:0]  frame_code;
    logic        f_none, f_single;
    logic [3:0]  dcnt_inc;

    assign tick       = (step_q == STEP_DIV);
    assign frame_done = tick && (cidx_q == 2'd3);
    assign col        = ~(4'b0001 << cidx_q);
    assign key_code   = code_q;
    assign key_valid  = valid_q;
    assign key_held   = held_q;

    // Per-frame hit accumulation; count saturates at 2 (= MULTI)
    always_comb begin
        samp  = ~row_s2_q;
        nhits = {2'b00, samp[0]} + {2'b00, samp[1]}
              + {2'b00, samp[2]} + {2'b00, samp[3]};
        rsel  = 2'd0;
        if (samp[1]) rsel = 2'd1;
        if (samp[2]) rsel = 2'd2;
        if (samp[3]) rsel = 2'd3;
        sum        = {1'b0, acc_n_q} + nhits;
        frame_n    = (sum >= 3'd2) ? 2'd2 : sum[1:0];
        frame_code = (nhits == 3'd1) ? key_map(rsel, cidx_q) : acc_code_q;
        f_none     = (frame_n == 2'd0);
        f_single   = (frame_n == 2'd1);

        step_d     = tick ? 32'd0 : step_q + 32'd1;
        cidx_d     = tick ? cidx_q + 2'd1 : cidx_q;
        acc_n_d    = acc_n_q;
        acc_code_d = acc_code_q;
        if (tick) begin
            acc_n_d    = frame_done ? 2'd0 : frame_n;
            acc_code_d = frame_done ? 4'd0 : frame_code;
        end
    end

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        dcnt_d   = dcnt_q;
        code_d   = code_q;
        valid_d  = 1'b0;
        held_d   = held_q;
        dcnt_inc = (dcnt_q >= DF) ? DF : dcnt_q + 4'd1;
        if (frame_done) begin
            unique case (state_q)
                IDLE: begin
                    if (f_single) begin
                        cand_d = frame_code;
                        dcnt_d = 4'd1;
                        if (DF <= 4'd1) begin
                            code_d  = frame_code;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            state_d = HELD;
                        end else begin
                            state_d = PRESS;
                        end
                    end
                end
                PRESS: begin
                    if (f_single && frame_code == cand_q) begin
                        dcnt_d = dcnt_inc;
                        if (dcnt_inc == DF) begin
                            code_d  = cand_q;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            state_d = HELD;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    // Any other key (single or multi) is ignored until released
                    if (f_none) begin
                        dcnt_d = 4'd1;
                        if (DF <= 4'd1) begin
                            held_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            state_d = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (f_none) begin
                        dcnt_d = dcnt_inc;
                        if (dcnt_inc == DF) begin
                            held_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_s1_q   <= 4'hF;
            row_s2_q   <= 4'hF;
            step_q     <= 32'd0;
            cidx_q     <= 2'd0;
            acc_n_q    <= 2'd0;
            acc_code_q <= 4'd0;
            state_q    <= IDLE;
            cand_q     <= 4'd0;
            dcnt_q     <= 4'd0;
            code_q     <= 4'd0;
            valid_q    <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            row_s1_q   <= row;
            row_s2_q   <= row_s1_q;
            step_q     <= step_d;
            cidx_q     <= cidx_d;
            acc_n_q    <= acc_n_d;
            acc_code_q <= acc_code_d;
            state_q    <= state_d;
            cand_q     <= cand_d;
            dcnt_q     <= dcnt_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            held_q     <= held_d;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad model.
// Tick every 10 cycles, frame of 40 cycles, 4-frame debounce.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed = 16'h0;

    int cyc;
    int pulses = 0;
    int wide = 0;
    int checks = 0;
    int fails = 0;
    int at;
    int base;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .basys_clk(100),
        .scan_hz(10),
        .debounce_frames(4)
    ) dut (
        .clock(clk),
        .reset(rst),
        .row(row),
        .col(col),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_held(key_held)
    );

    // Keypad: row r pulled low iff its column is driven low and key (r,c) is down
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!col[c] && pressed[r*4+c]) row[r] = 1'b0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (key_valid) pulses++;
        if (key_valid && prev_valid) wide++;
        prev_valid = key_valid;
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [15:0] keys);
        @(negedge clk);
        rst = 1'b1;
        pressed = keys;
        cycles(3);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int bound, output int when);
        when = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (key_valid) begin
                when = cyc;
                break;
            end
        end
    endtask

    initial begin
        // 1: reset values and column stepping
        #1;
        check_eq("rst_col", {28'd0, col}, 32'hE);
        check_eq("rst_code", {28'd0, key_code}, 32'h0);
        check_eq("rst_valid", {31'd0, key_valid}, 32'd0);
        check_eq("rst_held", {31'd0, key_held}, 32'd0);
        do_reset(16'h0);
        cycles(9);
        check_eq("col_c9", {28'd0, col}, 32'hE);
        cycles(1);
        check_eq("col_c10", {28'd0, col}, 32'hD);
        cycles(30);
        check_eq("col_c40", {28'd0, col}, 32'hE);

        // 2: hold '5' from reset release
        do_reset(16'h1 << 5);
        base = pulses;
        wait_valid(400, at);
        check_eq("k5_latency", at, 160);
        check_eq("k5_code", {28'd0, key_code}, 32'h5);
        check_eq("k5_held", {31'd0, key_held}, 32'd1);
        cycles(300);
        check_eq("k5_pulses", pulses - base, 1);
        check_eq("k5_still_held", {31'd0, key_held}, 32'd1);

        // 5: release, then press 'E'
        pressed = 16'h0;
        cycles(80);
        check_eq("rel_early_held", {31'd0, key_held}, 32'd1);
        cycles(160);
        check_eq("rel_held", {31'd0, key_held}, 32'd0);
        check_eq("rel_code", {28'd0, key_code}, 32'h5);
        base = pulses;
        pressed = 16'h1 << 14;
        wait_valid(400, at);
        check_eq("kE_seen", {31'd0, at >= 0}, 32'd1);
        check_eq("kE_code", {28'd0, key_code}, 32'hE);
        cycles(50);
        check_eq("kE_pulses", pulses - base, 1);
        pressed = 16'h0;
        cycles(300);
        check_eq("kE_rel_held", {31'd0, key_held}, 32'd0);

        // 3: bouncing '9' never accepted
        base = pulses;
        for (int i = 0; i < 17; i++) begin
            pressed = i[0] ? 16'h0 : (16'h1 << 10);
            cycles(60);
        end
        pressed = 16'h0;
        cycles(250);
        check_eq("bounce_pulses", pulses - base, 0);
        check_eq("bounce_code", {28'd0, key_code}, 32'hE);

        // 4: '1' and '2' together
        base = pulses;
        pressed = 16'h0003;
        cycles(400);
        check_eq("multi_pulses", pulses - base, 0);
        check_eq("multi_held", {31'd0, key_held}, 32'd0);
        pressed = 16'h0;
        cycles(100);

        // 6: reset during press debounce
        do_reset(16'h1 << 5);
        base = pulses;
        cycles(60);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_col", {28'd0, col}, 32'hE);
        check_eq("mid_rst_valid", {31'd0, key_valid}, 32'd0);
        cycles(5);
        rst = 1'b0;
        wait_valid(400, at);
        check_eq("post_rst_latency", at, 160);
        cycles(2);
        check_eq("post_rst_pulses", pulses - base, 1);
        check_eq("pulse_width", wide, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
